fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Fetch stage of the five-stage pipeline: drives instruction memory address from the PC and splits the 16-bit words.
//  Registers the decoded fields into the IF/ID buffer whose op_code feeds control_unit.
//  Handles the two-word LDM (opcode + immediate word), stall, flush/redirect and illegal opcodes.
//  An all-zero op_code is the bubble; the decoder turns it into all-zero controls.
// PARAMETERS
//  N         5       opcode width
//  ADDR_W    10      PC / instruction address width
//  DATA_W    16      instruction word and immediate width
//  RESET_PC  0       PC value loaded on reset
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  inst_addr    out  ADDR_W  instruction memory address (= pc, combinational from pc register)
//  inst_data    in   DATA_W  instruction word at inst_addr, valid in the same cycle (async-read memory)
//  stall        in   1       hold PC, FSM and IF/ID outputs
//  flush        in   1       kill the instruction in flight; load redirect_pc
//  redirect_pc  in   ADDR_W  PC loaded when flush=1
//  op_code      out  N       IF/ID opcode to control_unit (0 = bubble)
//  rdst         out  3       destination register field, inst[10:8]
//  rsrc         out  3       source register field, inst[7:5]
//  imm          out  DATA_W  immediate for LDM, else 0
//  if_valid     out  1       IF/ID holds a real instruction
//  illegal_op   out  1       one-cycle pulse: illegal opcode dropped
// BEHAVIOUR
//  Word format: [15:11] opcode, [10:8] rdst, [7:5] rsrc, [4:0] unused.
//  Legal opcodes: LDM=00001, STD=00010, ADD=00011, NOT=00100, NOP=00101.
//  Reset (async): pc=RESET_PC, state=S_FETCH, op_code/rdst/rsrc/imm=0, if_valid=0, illegal_op=0.
//  All outputs except inst_addr are registered.
//  Latency: the word read at pc in cycle t appears on the outputs after edge t+1.
//  FSM S_FETCH:
//    legal non-LDM: emit the fields, imm=0, if_valid=1, pc+=1.
//    LDM: latch opcode/rdst, emit a bubble (op_code=0, if_valid=0), pc+=1, go to S_IMM.
//    opcode 00000: emit a bubble, if_valid=0, pc+=1.
//    any other code: emit a bubble, pulse illegal_op, pc+=1.
//  FSM S_IMM: imm=inst_data, emit the latched LDM with if_valid=1, pc+=1, go to S_FETCH.
//  Priority per edge: rst > flush > stall > normal.
//  flush: outputs become a bubble (all zero, if_valid=0), pc=redirect_pc, state=S_FETCH; an LDM split across the flush is discarded.
//  stall (flush=0): pc, state and every output hold their values; illegal_op is 0 during stall.
//  PC arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-1 wraps to 0 with no flag. An LDM may straddle the wrap.
//  Reset in S_IMM aborts the LDM; no partial instruction is ever emitted.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0].
//    perf_fetched counts cycles with if_valid=1 and stall=0.
//    perf_bubbles counts bubble cycles (if_valid=0, stall=0).
//    Both counters saturate at all-ones and are cleared by rst.
//  FETCH_PERF_CNT_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package pipeline_pkg holds:
//    opcode constants OP_LDM..OP_NOP and OP_BUBBLE=0 (shared with control_unit);
//    field-slice constants OPC_HI/LO, RDST_HI/LO, RSRC_HI/LO;
//    fetch state encoding (S_FETCH, S_IMM).
//  One sub-module, fetch_pc_counter: pc register with reset, hold, load(redirect) and increment-with-wrap.
//  The FSM and IF/ID buffer live in fetch_unit.
// TESTING
//  Reset, then memory [0]=ADD r1,r2 (0x1940), [1]=NOT r3 (0x2300):
//    op_code 00011/rdst1/rsrc2, then 00100/rdst3; if_valid high; pc 0->1->2.
//  LDM r4 at [2]=0x0C00 with immediate [3]=0xBEEF:
//    one bubble cycle, then op_code=00001, rdst=4, imm=0xBEEF, if_valid=1; next fetch at pc=4.
//  stall held 3 cycles mid-stream: inst_addr and all outputs frozen; resume with no lost or duplicated instruction.
//  flush with redirect_pc=0x040 while in S_IMM:
//    next edge outputs a bubble, pc=0x040; LDM never emitted; next word fetched from 0x040.
//  Word 0xF800 (opcode 11111): bubble emitted, illegal_op high for exactly 1 cycle, pc advances.
//  pc=0x3FF (ADDR_W=10) holding an LDM: immediate read from 0x000, LDM emitted correctly, pc=0x001.
//    With FETCH_PERF_CNT_EN, the counters match the scoreboard across the whole run.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode values (also used by control_unit),
// instruction field positions and the fetch state encoding.
package pipeline_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_BUBBLE = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDM    = 5'b00001;
  localparam logic [OPC_W-1:0] OP_STD    = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD    = 5'b00011;
  localparam logic [OPC_W-1:0] OP_NOT    = 5'b00100;
  localparam logic [OPC_W-1:0] OP_NOP    = 5'b00101;

  // Field positions inside a 16-bit instruction word; bits [4:0] are unused.
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 11;
  localparam int RDST_HI = 10;
  localparam int RDST_LO = 8;
  localparam int RSRC_HI = 7;
  localparam int RSRC_LO = 5;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_IMM   = 1'b1
  } fetch_state_t;

  // True for every opcode the decoder knows, including LDM.
  function automatic logic is_legal_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_LDM) || (opc == OP_STD) || (opc == OP_ADD) ||
           (opc == OP_NOT) || (opc == OP_NOP);
  endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter for the fetch stage: reset value, redirect load, hold and
// increment that wraps modulo 2^ADDR_W.
module fetch_pc_counter #(
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              hold,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_reg;

  // Redirect wins over hold; otherwise step by one and let the adder wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_VAL;
    end else if (load) begin
      pc_reg <= load_pc;
    end else if (!hold) begin
      pc_reg <= pc_reg + 1'b1;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: addresses instruction memory from the PC, splits each word into
// opcode/rdst/rsrc and registers them into the IF/ID buffer. LDM takes two
// words (opcode word then immediate). Optional performance counters are built
// when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int N        = 5,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [N-1:0]      op_code,
  output logic [2:0]        rdst,
  output logic [2:0]        rsrc,
  output logic [DATA_W-1:0] imm,
  output logic              if_valid,
  output logic              illegal_op
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  fetch_state_t      state_reg, state_next;
  logic [N-1:0]      op_code_reg, op_code_next;
  logic [2:0]        rdst_reg, rdst_next;
  logic [2:0]        rsrc_reg, rsrc_next;
  logic [DATA_W-1:0] imm_reg, imm_next;
  logic              if_valid_reg, if_valid_next;
  logic              illegal_reg, illegal_next;
  logic [2:0]        ldm_rdst_reg, ldm_rdst_next;
  logic [2:0]        ldm_rsrc_reg, ldm_rsrc_next;

  logic [OPC_W-1:0]  opc;
  logic [2:0]        word_rdst;
  logic [2:0]        word_rsrc;
  logic              unused_low_bits;

  assign opc             = inst_data[OPC_HI:OPC_LO];
  assign word_rdst       = inst_data[RDST_HI:RDST_LO];
  assign word_rsrc       = inst_data[RSRC_HI:RSRC_LO];
  assign unused_low_bits = ^inst_data[RSRC_LO-1:0];

  fetch_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (flush),
    .load_pc (redirect_pc),
    .hold    (stall),
    .pc      (inst_addr)
  );

  // Next-state and IF/ID contents: flush beats stall, stall freezes everything.
  always_comb begin
    state_next    = state_reg;
    op_code_next  = op_code_reg;
    rdst_next     = rdst_reg;
    rsrc_next     = rsrc_reg;
    imm_next      = imm_reg;
    if_valid_next = if_valid_reg;
    illegal_next  = 1'b0;
    ldm_rdst_next = ldm_rdst_reg;
    ldm_rsrc_next = ldm_rsrc_reg;

    if (flush) begin
      // Any half-fetched LDM is dropped here.
      state_next    = S_FETCH;
      op_code_next  = '0;
      rdst_next     = '0;
      rsrc_next     = '0;
      imm_next      = '0;
      if_valid_next = 1'b0;
    end else if (!stall) begin
      // Bubble unless a case below emits a real instruction.
      op_code_next  = '0;
      rdst_next     = '0;
      rsrc_next     = '0;
      imm_next      = '0;
      if_valid_next = 1'b0;
      case (state_reg)
        S_FETCH: begin
          if (opc == OP_LDM) begin
            ldm_rdst_next = word_rdst;
            ldm_rsrc_next = word_rsrc;
            state_next    = S_IMM;
          end else if (opc == OP_BUBBLE) begin
            state_next = S_FETCH;
          end else if (is_legal_op(opc)) begin
            op_code_next  = N'(opc);
            rdst_next     = word_rdst;
            rsrc_next     = word_rsrc;
            if_valid_next = 1'b1;
          end else begin
            illegal_next = 1'b1;
          end
        end
        S_IMM: begin
          op_code_next  = N'(OP_LDM);
          rdst_next     = ldm_rdst_reg;
          rsrc_next     = ldm_rsrc_reg;
          imm_next      = inst_data;
          if_valid_next = 1'b1;
          state_next    = S_FETCH;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  // State and IF/ID buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      op_code_reg  <= '0;
      rdst_reg     <= '0;
      rsrc_reg     <= '0;
      imm_reg      <= '0;
      if_valid_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      ldm_rdst_reg <= '0;
      ldm_rsrc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      op_code_reg  <= op_code_next;
      rdst_reg     <= rdst_next;
      rsrc_reg     <= rsrc_next;
      imm_reg      <= imm_next;
      if_valid_reg <= if_valid_next;
      illegal_reg  <= illegal_next;
      ldm_rdst_reg <= ldm_rdst_next;
      ldm_rsrc_reg <= ldm_rsrc_next;
    end
  end

  assign op_code    = op_code_reg;
  assign rdst       = rdst_reg;
  assign rsrc       = rsrc_reg;
  assign imm        = imm_reg;
  assign if_valid   = if_valid_reg;
  assign illegal_op = illegal_reg;

`ifdef FETCH_PERF_CNT_EN
  // Index 0 counts valid cycles, index 1 bubble cycles; stalled cycles are ignored.
  logic [1:0] perf_inc;
  assign perf_inc[0] = if_valid_reg & ~stall;
  assign perf_inc[1] = ~if_valid_reg & ~stall;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      // Saturating event counter.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (perf_inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign perf_fetched = g_perf[0].cnt_reg;
  assign perf_bubbles = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed program plus randomized stall/flush
// traffic over random memory, checked every cycle against a behavioural model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [9:0]  inst_addr;
  logic [15:0] inst_data;
  logic        stall;
  logic        flush;
  logic [9:0]  redirect_pc;
  logic [4:0]  op_code;
  logic [2:0]  rdst;
  logic [2:0]  rsrc;
  logic [15:0] imm;
  logic        if_valid;
  logic        illegal_op;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [1024];

  fetch_unit #(.N(5), .ADDR_W(10), .DATA_W(16), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .op_code     (op_code),
    .rdst        (rdst),
    .rsrc        (rsrc),
    .imm         (imm),
    .if_valid    (if_valid),
    .illegal_op  (illegal_op)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  assign inst_data = mem[inst_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_pc;
  bit          m_pend;       // first word of an LDM has been consumed
  logic [2:0]  m_prdst, m_prsrc;
  logic [4:0]  e_op;
  logic [2:0]  e_rdst, e_rsrc;
  logic [15:0] e_imm;
  logic        e_valid, e_ill;
  longint      e_fetched, e_bubbles;

  function automatic bit legal(input logic [4:0] o);
    return (o >= 5'd1) && (o <= 5'd5);
  endfunction

  task automatic m_bubble();
    e_op = 0; e_rdst = 0; e_rsrc = 0; e_imm = 0; e_valid = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    logic [15:0] w;
    if (rst) begin
      m_pc = 0; m_pend = 0; m_prdst = 0; m_prsrc = 0;
      m_bubble(); e_ill = 0; e_fetched = 0; e_bubbles = 0;
    end else begin
      w = mem[m_pc];
      if (!stall) begin
        if (e_valid) begin if (e_fetched < 64'hFFFF_FFFF) e_fetched++; end
        else begin if (e_bubbles < 64'hFFFF_FFFF) e_bubbles++; end
      end
      e_ill = 0;
      if (flush) begin
        m_bubble(); m_pend = 0; m_pc = int'(redirect_pc);
      end else if (!stall) begin
        m_bubble();
        if (m_pend) begin
          e_op = 5'd1; e_rdst = m_prdst; e_rsrc = m_prsrc; e_imm = w; e_valid = 1;
          m_pend = 0;
        end else if (w[15:11] == 5'd1) begin
          m_pend = 1; m_prdst = w[10:8]; m_prsrc = w[7:5];
        end else if (w[15:11] == 5'd0) begin
          m_pend = 0;
        end else if (legal(w[15:11])) begin
          e_op = w[15:11]; e_rdst = w[10:8]; e_rsrc = w[7:5]; e_valid = 1;
        end else begin
          e_ill = 1;
        end
        m_pc = (m_pc + 1) % 1024;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [38:0] act, exp_v;
    act   = {inst_addr, op_code, rdst, rsrc, imm, if_valid, illegal_op};
    exp_v = {m_pc[9:0], e_op, e_rdst, e_rsrc, e_imm, e_valid, e_ill};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL cycle @%0t: got addr=%h op=%b rd=%0d rs=%0d imm=%h v=%b ill=%b, expected addr=%h op=%b rd=%0d rs=%0d imm=%h v=%b ill=%b",
               $time, inst_addr, op_code, rdst, rsrc, imm, if_valid, illegal_op,
               m_pc[9:0], e_op, e_rdst, e_rsrc, e_imm, e_valid, e_ill);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_fetched !== 32'(e_fetched) || perf_bubbles !== 32'(e_bubbles)) begin
      errors++;
      $display("FAIL perf @%0t: got fetched=%0d bubbles=%0d, expected fetched=%0d bubbles=%0d",
               $time, perf_fetched, perf_bubbles, e_fetched, e_bubbles);
    end
`endif
  end

  // ---------------- directed literal checks ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end else begin
      $display("check %s ok: %h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] rand_word();
    logic [4:0] o;
    case ($urandom_range(0, 9))
      0:       o = 5'd0;
      1, 2:    o = 5'd1;
      3, 4, 5: o = 5'($urandom_range(2, 5));
      6:       o = 5'($urandom_range(6, 31));
      default: o = 5'($urandom_range(0, 31));
    endcase
    return {o, 11'($urandom)};
  endfunction

  task automatic load_program();
    mem[0] = 16'h1940;  // ADD r1,r2
    mem[1] = 16'h2300;  // NOT r3
    mem[2] = 16'h0C00;  // LDM r4
    mem[3] = 16'hBEEF;
    mem[4] = 16'hF800;  // illegal
    mem[5] = 16'h1940;
    mem[6] = 16'h0C00;  // LDM r4, cut by flush
    mem[7] = 16'h1234;
    mem[10'h040] = 16'h2300;
    mem[10'h100] = 16'h0C00;
    mem[10'h101] = 16'h5555;
    mem[10'h3FF] = 16'h0C00;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    load_program();
    tick(); tick();
    rst = 1'b0;
    chk("reset_op", 32'(op_code), 32'h0);
    chk("reset_valid", 32'(if_valid), 32'h0);
    chk("reset_addr", 32'(inst_addr), 32'h0);

    tick();
    chk("add_fields", {op_code, rdst, rsrc, if_valid}, {5'b00011, 3'd1, 3'd2, 1'b1});
    chk("add_pc", 32'(inst_addr), 32'h1);
    tick();
    chk("not_fields", {op_code, rdst, rsrc, if_valid}, {5'b00100, 3'd3, 3'd0, 1'b1});
    chk("not_pc", 32'(inst_addr), 32'h2);
    tick();
    chk("ldm_bubble", {op_code, if_valid}, {5'b0, 1'b0});
    tick();
    chk("ldm_fields", {op_code, rdst, if_valid}, {5'b00001, 3'd4, 1'b1});
    chk("ldm_imm", 32'(imm), 32'hBEEF);
    chk("ldm_next_pc", 32'(inst_addr), 32'h4);
    tick();
    chk("illegal_pulse", {op_code, if_valid, illegal_op}, {5'b0, 1'b0, 1'b1});
    chk("illegal_pc", 32'(inst_addr), 32'h5);
    tick();
    chk("illegal_one_cycle", 32'(illegal_op), 32'h0);
    chk("after_illegal_op", 32'(op_code), 32'h3);

    stall = 1'b1;
    tick(); tick(); tick();
    chk("stall_addr", 32'(inst_addr), 32'h6);
    chk("stall_hold", {op_code, rdst, rsrc, if_valid}, {5'b00011, 3'd1, 3'd2, 1'b1});
    stall = 1'b0;
    tick();
    chk("resume_ldm_bubble", {op_code, if_valid, 6'(inst_addr)}, {5'b0, 1'b0, 6'd7});

    flush = 1'b1; redirect_pc = 10'h040;
    tick();
    flush = 1'b0;
    chk("flush_bubble", {op_code, if_valid}, {5'b0, 1'b0});
    chk("flush_pc", 32'(inst_addr), 32'h040);
    tick();
    chk("after_flush", {op_code, rdst, if_valid}, {5'b00100, 3'd3, 1'b1});

    flush = 1'b1; redirect_pc = 10'h3FF;
    tick();
    flush = 1'b0;
    tick();
    chk("wrap_pc", 32'(inst_addr), 32'h0);
    tick();
    chk("wrap_ldm", {op_code, rdst, if_valid}, {5'b00001, 3'd4, 1'b1});
    chk("wrap_imm", 32'(imm), 32'h1940);
    chk("wrap_next_pc", 32'(inst_addr), 32'h1);

    // randomized traffic over random memory
    for (int i = 0; i < 1024; i++) mem[i] = rand_word();
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 12) == 0);
      redirect_pc = 10'($urandom);
      tick();
    end
    stall = 1'b0; flush = 1'b0;

    // reset while the LDM immediate is pending
    load_program();
    flush = 1'b1; redirect_pc = 10'h100;
    tick();
    flush = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    chk("rst_in_imm", {op_code, if_valid, 10'(inst_addr)}, {5'b0, 1'b0, 10'h0});
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_fetch", {op_code, rdst, if_valid}, {5'b00011, 3'd1, 1'b1});
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
